// File: rtl/uart_rx_ctrl_if.sv
// Bus bundle for uart_rx_ctrl: oversample tick, serial line, line-format
// configuration, the frame detector handshake and the received-word outputs.
// The master side drives the receiver inputs; the slave side is the receiver.
interface uart_rx_ctrl_if;
  logic       baud_tick;
  logic       rxd;
  logic       rx_en;
  logic [1:0] wls;
  logic       pen;
  logic       eps;
  logic       receive_done;
  logic       receive_frame_counter_en;
  logic       receive_frame_counter_clear;
  logic       sample_edge;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_error;
  logic       framing_error;

  modport master (
    output baud_tick, rxd, rx_en, wls, pen, eps, receive_done,
    input  receive_frame_counter_en, receive_frame_counter_clear, sample_edge,
           rx_data, rx_valid, parity_error, framing_error
  );

  modport slave (
    input  baud_tick, rxd, rx_en, wls, pen, eps, receive_done,
    output receive_frame_counter_en, receive_frame_counter_clear, sample_edge,
           rx_data, rx_valid, parity_error, framing_error
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller, 16x oversampling.
// Finds the start bit, strobes mid-bit samples, assembles 5..8 data bits plus
// optional parity, and reports the word with parity/framing status once the
// external frame detector flags the stop-bit sample.
// Optional build macro: UART_RX_MAJORITY_EN -- each bit decision becomes a
// 2-of-3 vote over the last three oversample ticks instead of a single sample.
module uart_rx_ctrl (
  input logic           pclk,
  input logic           presetn,
  uart_rx_ctrl_if.slave rx_if
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    DATA     = 2'd2,
    BRK_WAIT = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] os_cnt_q, os_cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic       par_q, par_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       parity_error_q, parity_error_d;
  logic       framing_error_q, framing_error_d;
  logic       clear_q, clear_d;

  logic       bit_val;
  logic       sample_edge;
  logic [3:0] n_bits;
  logic [7:0] data_mask;
  logic [7:0] word;

`ifdef UART_RX_MAJORITY_EN
  // hist_q[0] holds rxd from the previous tick, hist_q[1] from the one before
  logic [1:0] hist_q, hist_d;

  // Shift the line into the vote history on every oversample tick
  always_comb begin
    hist_d = hist_q;
    if (rx_if.baud_tick) begin
      hist_d = {hist_q[0], rx_if.rxd};
    end
  end

  // Vote history register, idles at the line's rest level
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      hist_q <= '1;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign bit_val = (hist_q[1] & hist_q[0]) |
                   (hist_q[1] & rx_if.rxd) |
                   (hist_q[0] & rx_if.rxd);
`else
  assign bit_val = rx_if.rxd;
`endif

  assign n_bits      = 4'd5 + {2'b00, rx_if.wls};
  assign sample_edge = rx_if.baud_tick && (state_q == DATA) && (os_cnt_q == 4'd15);
  assign word        = shift_q & data_mask;

  // Mask of the data bits in use for the selected word length
  always_comb begin
    data_mask = 8'hFF;
    unique case (rx_if.wls)
      2'b00:   data_mask = 8'h1F;
      2'b01:   data_mask = 8'h3F;
      2'b10:   data_mask = 8'h7F;
      default: data_mask = 8'hFF;
    endcase
  end

  // Frame sequencing, bit assembly and word/status capture
  always_comb begin
    state_d         = state_q;
    os_cnt_d        = os_cnt_q;
    idx_d           = idx_q;
    shift_d         = shift_q;
    par_d           = par_q;
    rx_data_d       = rx_data_q;
    rx_valid_d      = 1'b0;
    parity_error_d  = parity_error_q;
    framing_error_d = framing_error_q;
    clear_d         = 1'b0;

    if (!rx_if.rx_en) begin
      state_d  = IDLE;
      os_cnt_d = '0;
      idx_d    = '0;
      clear_d  = 1'b1;
    end else if (rx_if.baud_tick) begin
      os_cnt_d = os_cnt_q + 4'd1;
      unique case (state_q)
        IDLE: begin
          os_cnt_d = '0;
          if (!rx_if.rxd) begin
            state_d = START;
          end
        end

        START: begin
          if (os_cnt_q == 4'd7) begin
            os_cnt_d = '0;
            if (bit_val) begin
              state_d = IDLE;
            end else begin
              state_d = DATA;
              idx_d   = '0;
              shift_d = '0;
              par_d   = 1'b0;
              clear_d = 1'b1;
            end
          end
        end

        DATA: begin
          if (os_cnt_q == 4'd15) begin
            if (!rx_if.receive_done) begin
              if (idx_q < n_bits) begin
                shift_d[idx_q[2:0]] = bit_val;
              end else if (idx_q == n_bits) begin
                par_d = bit_val;
              end
              if (idx_q != 4'd15) begin
                idx_d = idx_q + 4'd1;
              end
            end else begin
              // Stop-bit sample: publish the word and leave the frame
              rx_valid_d      = 1'b1;
              rx_data_d       = word;
              framing_error_d = ~bit_val;
              parity_error_d  = rx_if.pen & ((^word ^ par_q) != ~rx_if.eps);
              idx_d           = '0;
              os_cnt_d        = '0;
              state_d         = bit_val ? IDLE : BRK_WAIT;
            end
          end
        end

        BRK_WAIT: begin
          os_cnt_d = '0;
          if (rx_if.rxd) begin
            state_d = IDLE;
          end
        end

        default: begin
          state_d  = IDLE;
          os_cnt_d = '0;
        end
      endcase
    end
  end

  // State, counters and output registers
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q         <= IDLE;
      os_cnt_q        <= '0;
      idx_q           <= '0;
      shift_q         <= '0;
      par_q           <= 1'b0;
      rx_data_q       <= '0;
      rx_valid_q      <= 1'b0;
      parity_error_q  <= 1'b0;
      framing_error_q <= 1'b0;
      clear_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      os_cnt_q        <= os_cnt_d;
      idx_q           <= idx_d;
      shift_q         <= shift_d;
      par_q           <= par_d;
      rx_data_q       <= rx_data_d;
      rx_valid_q      <= rx_valid_d;
      parity_error_q  <= parity_error_d;
      framing_error_q <= framing_error_d;
      clear_q         <= clear_d;
    end
  end

  assign rx_if.sample_edge                 = sample_edge;
  assign rx_if.receive_frame_counter_en    = sample_edge & ~rx_if.receive_done;
  assign rx_if.receive_frame_counter_clear = clear_q;
  assign rx_if.rx_data                     = rx_data_q;
  assign rx_if.rx_valid                    = rx_valid_q;
  assign rx_if.parity_error                = parity_error_q;
  assign rx_if.framing_error               = framing_error_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: drives serial frames tick by tick from a line
// waveform, predicts every word from the waveform, and checks sample strobes
// and held outputs every cycle plus literal values per directed case.
module tb_uart_rx_ctrl;

  logic pclk;
  logic presetn;

  uart_rx_ctrl_if rx ();

  uart_rx_ctrl dut (
    .pclk    (pclk),
    .presetn (presetn),
    .rx_if   (rx)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Line level per oversample tick for the frame being driven
  logic       wave [0:511];
  int         wave_len;

  logic       exp_sample;
  logic [9:0] exp_q [$];
  logic [7:0] hold_data;
  logic       hold_pe;
  logic       hold_fe;

  int errors;
  int checks;
  int n_en;
  int n_clr;
  int n_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit decision for bit period p, taken at offset 8 of the period
  function automatic logic dec(input int p);
    int t;
    t = 16 * p + 8;
`ifdef UART_RX_MAJORITY_EN
    return (wave[t-2] & wave[t-1]) | (wave[t-2] & wave[t]) | (wave[t-1] & wave[t]);
`else
    return wave[t];
`endif
  endfunction

  task automatic fill_frame(input logic [7:0] data, input int n, input logic p,
                            input logic par, input logic stop);
    int s;
    for (int t = 0; t < 512; t++) wave[t] = 1'b1;
    for (int k = 0; k < 16; k++) wave[k] = 1'b0;
    for (int j = 0; j < n; j++)
      for (int k = 0; k < 16; k++) wave[16*(j+1)+k] = data[j];
    if (p)
      for (int k = 0; k < 16; k++) wave[16*(n+1)+k] = par;
    s = 1 + n + int'(p);
    for (int k = 0; k < 16; k++) wave[16*s+k] = stop;
    wave_len = 16 * (s + 1) + 8;
  endtask

  // Drive the first 'upto' ticks of the waveform and predict the outcome
  task automatic run_line(input int upto, output int d_en, output int d_clr, output int d_val);
    int         n, s, stop_t, en0, clr0, val0, ones;
    logic       started, par_b, stop_b, pe;
    logic [7:0] d;
    n      = 5 + int'(rx.wls);
    s      = 1 + n + int'(rx.pen);
    stop_t = 16 * s + 8;
    en0    = n_en;
    clr0   = n_clr;
    val0   = n_val;
    started = !wave[0] && !dec(0);
    if (started && upto > stop_t) begin
      d = '0;
      ones = 0;
      for (int j = 0; j < n; j++) begin
        d[j] = dec(j + 1);
        ones += int'(d[j]);
      end
      par_b = rx.pen ? dec(n + 1) : 1'b0;
      ones += int'(par_b);
      stop_b = dec(s);
      pe = rx.pen && (rx.eps ? (ones % 2 == 1) : (ones % 2 == 0));
      exp_q.push_back({d, pe, ~stop_b});
    end
    for (int t = 0; t < upto; t++) begin
      @(posedge pclk); #1;
      rx.baud_tick    = 1'b1;
      rx.rxd          = wave[t];
      exp_sample      = started && (t % 16 == 8) && (t / 16 >= 1) && (t / 16 <= s);
      rx.receive_done = started && (t == stop_t);
      @(posedge pclk); #1;
      rx.baud_tick    = 1'b0;
      rx.receive_done = 1'b0;
      exp_sample      = 1'b0;
    end
    repeat (3) @(posedge pclk);
    #1;
    chk("missing_rx_valid", exp_q.size(), 0);
    d_en  = n_en - en0;
    d_clr = n_clr - clr0;
    d_val = n_val - val0;
  endtask

  task automatic frame(input logic [7:0] data, input logic [1:0] w, input logic p,
                       input logic e, input logic par, input logic stop,
                       output int d_en, output int d_clr, output int d_val);
    rx.wls = w;
    rx.pen = p;
    rx.eps = e;
    fill_frame(data, 5 + int'(w), p, par, stop);
    run_line(wave_len, d_en, d_clr, d_val);
  endtask

  // Per-cycle comparison of strobes and held word/status against the model
  task automatic compare_loop();
    logic [9:0] e;
    forever begin
      @(negedge pclk);
      if (rx.receive_frame_counter_en)    n_en++;
      if (rx.receive_frame_counter_clear) n_clr++;
      chk("sample_edge", 32'(rx.sample_edge), 32'(exp_sample));
      chk("counter_en", 32'(rx.receive_frame_counter_en),
          32'(exp_sample & ~rx.receive_done));
      if (rx.rx_valid) begin
        n_val++;
        if (exp_q.size() == 0) begin
          chk("unexpected_rx_valid", 32'(rx.rx_valid), 0);
        end else begin
          e = exp_q.pop_front();
          hold_data = e[9:2];
          hold_pe   = e[1];
          hold_fe   = e[0];
        end
      end
      chk("rx_data", 32'(rx.rx_data), 32'(hold_data));
      chk("parity_error", 32'(rx.parity_error), 32'(hold_pe));
      chk("framing_error", 32'(rx.framing_error), 32'(hold_fe));
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rx_data"}, 32'(rx.rx_data), 0);
    chk({tag, "_rx_valid"}, 32'(rx.rx_valid), 0);
    chk({tag, "_parity_error"}, 32'(rx.parity_error), 0);
    chk({tag, "_framing_error"}, 32'(rx.framing_error), 0);
    chk({tag, "_counter_en"}, 32'(rx.receive_frame_counter_en), 0);
    chk({tag, "_counter_clear"}, 32'(rx.receive_frame_counter_clear), 0);
    chk({tag, "_sample_edge"}, 32'(rx.sample_edge), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_en, d_clr, d_val;
    errors = 0; checks = 0; n_en = 0; n_clr = 0; n_val = 0;
    presetn         = 1'b0;
    rx.baud_tick    = 1'b0;
    rx.rxd          = 1'b1;
    rx.rx_en        = 1'b1;
    rx.wls          = 2'b11;
    rx.pen          = 1'b0;
    rx.eps          = 1'b0;
    rx.receive_done = 1'b0;
    exp_sample      = 1'b0;
    hold_data       = '0;
    hold_pe         = 1'b0;
    hold_fe         = 1'b0;
    fork
      compare_loop();
    join_none

    repeat (3) @(posedge pclk);
    #1;
    check_all_zero("reset");
    presetn = 1'b1;
    repeat (2) @(posedge pclk);

    // 8 data bits, even parity, correct parity bit
    frame(8'hA5, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, d_en, d_clr, d_val);
    chk("a5_even_data", 32'(rx.rx_data), 32'h A5);
    chk("a5_even_pe", 32'(rx.parity_error), 0);
    chk("a5_even_fe", 32'(rx.framing_error), 0);
    chk("a5_even_en_pulses", d_en, 9);
    chk("a5_even_clear_pulses", d_clr, 1);
    chk("a5_even_valid_pulses", d_val, 1);

    // Same frame, odd parity selected -> parity error
    frame(8'hA5, 2'b11, 1'b1, 1'b0, 1'b0, 1'b1, d_en, d_clr, d_val);
    chk("a5_odd_data", 32'(rx.rx_data), 32'h A5);
    chk("a5_odd_pe", 32'(rx.parity_error), 1);
    chk("a5_odd_en_pulses", d_en, 9);

    // 5 data bits, no parity
    frame(8'h1F, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, d_en, d_clr, d_val);
    chk("w5_data", 32'(rx.rx_data), 32'h1F);
    chk("w5_upper_zero", 32'(rx.rx_data[7:5]), 0);
    chk("w5_pe", 32'(rx.parity_error), 0);
    chk("w5_en_pulses", d_en, 5);

    // 6 data bits, odd parity satisfied (3 ones + parity 0)
    frame(8'h2A, 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, d_en, d_clr, d_val);
    chk("w6_data", 32'(rx.rx_data), 32'h2A);
    chk("w6_pe", 32'(rx.parity_error), 0);
    chk("w6_en_pulses", d_en, 7);

    // 7 data bits, even parity violated (2 ones + parity 1)
    frame(8'h41, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1, d_en, d_clr, d_val);
    chk("w7_data", 32'(rx.rx_data), 32'h41);
    chk("w7_pe", 32'(rx.parity_error), 1);
    chk("w7_en_pulses", d_en, 8);

    // False start: low for 4 ticks only
    rx.wls = 2'b11; rx.pen = 1'b0;
    for (int t = 0; t < 512; t++) wave[t] = (t >= 4);
    run_line(48, d_en, d_clr, d_val);
    chk("false_start_clear", d_clr, 0);
    chk("false_start_valid", d_val, 0);
    chk("false_start_en", d_en, 0);
    chk("false_start_hold_data", 32'(rx.rx_data), 32'h41);

    // Break: line low for two frame times, then released
    for (int t = 0; t < 512; t++) wave[t] = (t >= 320);
    run_line(340, d_en, d_clr, d_val);
    chk("break_valid", d_val, 1);
    chk("break_data", 32'(rx.rx_data), 0);
    chk("break_fe", 32'(rx.framing_error), 1);
    chk("break_pe", 32'(rx.parity_error), 0);
    chk("break_clear", d_clr, 1);
    chk("break_en", d_en, 8);

    frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, d_en, d_clr, d_val);
    chk("after_break_data", 32'(rx.rx_data), 32'h5A);
    chk("after_break_fe", 32'(rx.framing_error), 0);

    // Reset in the middle of a frame
    fill_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    run_line(60, d_en, d_clr, d_val);
    chk("pre_reset_valid", d_val, 0);
    @(posedge pclk); #1;
    presetn   = 1'b0;
    hold_data = '0;
    hold_pe   = 1'b0;
    hold_fe   = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge pclk);
    #1;
    presetn = 1'b1;
    rx.rxd  = 1'b1;
    frame(8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, d_en, d_clr, d_val);
    chk("post_reset_data", 32'(rx.rx_data), 32'hC3);
    chk("post_reset_valid", d_val, 1);

    // Receiver disabled mid-frame
    fill_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
    run_line(50, d_en, d_clr, d_val);
    chk("pre_disable_valid", d_val, 0);
    @(posedge pclk); #1;
    rx.rx_en = 1'b0;
    rx.rxd   = 1'b1;
    repeat (2) @(negedge pclk);
    chk("disable_clear_1", 32'(rx.receive_frame_counter_clear), 1);
    @(negedge pclk);
    chk("disable_clear_2", 32'(rx.receive_frame_counter_clear), 1);
    chk("disable_hold_data", 32'(rx.rx_data), 32'hC3);
    @(posedge pclk); #1;
    rx.rx_en = 1'b1;
    repeat (2) @(posedge pclk);
    frame(8'h96, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, d_en, d_clr, d_val);
    chk("post_disable_data", 32'(rx.rx_data), 32'h96);
    chk("post_disable_clear", d_clr, 1);

    // One-tick glitch high on the decision tick of data bit 3
    rx.wls = 2'b11; rx.pen = 1'b0;
    fill_frame(8'h00, 8, 1'b0, 1'b0, 1'b1);
    wave[72] = 1'b1;
    run_line(wave_len, d_en, d_clr, d_val);
`ifdef UART_RX_MAJORITY_EN
    chk("glitch_data", 32'(rx.rx_data), 32'h00);
`else
    chk("glitch_data", 32'(rx.rx_data), 32'h08);
`endif
    chk("glitch_valid", d_val, 1);

    repeat (4) @(posedge pclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
